// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the core's single-port
// unified memory: one issue cycle per access, fixed read latency, read-return pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                r0_req,
  input  logic                r0_we,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W/8-1:0] r0_wmask,
  output logic                r0_gnt,
  output logic                r0_rvalid,
  output logic [DATA_W-1:0]   r0_rdata,
  input  logic                r1_req,
  input  logic                r1_we,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r1_wmask,
  output logic                r1_gnt,
  output logic                r1_rvalid,
  output logic [DATA_W-1:0]   r1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state;
  logic               last_grant;
  logic               winner;
  logic [CNT_W-1:0]   cnt;

  logic               sel_we_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_wdata_c;
  logic [MASK_W-1:0]  sel_wmask_c;

  // Grant only in IDLE; on a tie the port that did not win last time goes first.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (state == IDLE) begin
      r0_gnt = r0_req & (~r1_req | last_grant);
      r1_gnt = r1_req & (~r0_req | ~last_grant);
    end
  end

  always_comb begin
    sel_we_c    = r0_we;
    sel_addr_c  = r0_addr;
    sel_wdata_c = r0_wdata;
    sel_wmask_c = r0_wmask;
    if (r1_gnt) begin
      sel_we_c    = r1_we;
      sel_addr_c  = r1_addr;
      sel_wdata_c = r1_wdata;
      sel_wmask_c = r1_wmask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      cnt        <= '0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_gnt || r1_gnt) begin
            winner     <= r1_gnt;
            last_grant <= r1_gnt;
            mem_en     <= 1'b1;
            mem_we     <= sel_we_c;
            mem_addr   <= sel_addr_c;
            mem_wdata  <= sel_wdata_c;
            mem_wmask  <= sel_we_c ? sel_wmask_c : '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_wmask <= '0;
          if (mem_we) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_W'(1);
            state <= WAIT;
          end
        end
        WAIT: begin
          // mem_rdata is valid exactly when the counter reaches the latency
          if (cnt == CNT_W'(MEM_LATENCY)) begin
            if (winner) begin
              r1_rdata  <= mem_rdata;
              r1_rvalid <= 1'b1;
            end else begin
              r0_rdata  <= mem_rdata;
              r0_rvalid <= 1'b1;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four instances at MEM_LATENCY 1..4 share the
// requester inputs; each has a memory model driving valid data only in its latency cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
  logic [3:0]  r0_wmask = '0, r1_wmask = '0;

  logic [3:0]  r0_gnt_a, r1_gnt_a, r0_rvalid_a, r1_rvalid_a, mem_en_a, mem_we_a;
  logic [31:0] r0_rdata_a [4];
  logic [31:0] r1_rdata_a [4];
  logic [31:0] mem_addr_a [4];
  logic [31:0] mem_wdata_a [4];
  logic [31:0] mem_rdata_a [4];
  logic [3:0]  mem_wmask_a [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] model_data(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : ~a;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    logic [3:0] h = '0;
    always @(posedge clk) h <= {h[2:0], mem_en_a[k] & ~mem_we_a[k]};
    assign mem_rdata_a[k] = h[k] ? model_data(mem_addr_a[k]) : 32'h0BAD_0000;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(k + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .r0_req    (r0_req),
      .r0_we     (r0_we),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_wmask  (r0_wmask),
      .r0_gnt    (r0_gnt_a[k]),
      .r0_rvalid (r0_rvalid_a[k]),
      .r0_rdata  (r0_rdata_a[k]),
      .r1_req    (r1_req),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_wmask  (r1_wmask),
      .r1_gnt    (r1_gnt_a[k]),
      .r1_rvalid (r1_rvalid_a[k]),
      .r1_rdata  (r1_rdata_a[k]),
      .mem_en    (mem_en_a[k]),
      .mem_we    (mem_we_a[k]),
      .mem_addr  (mem_addr_a[k]),
      .mem_wdata (mem_wdata_a[k]),
      .mem_wmask (mem_wmask_a[k]),
      .mem_rdata (mem_rdata_a[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    r0_req = 1'b0;
    r1_req = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    #1;
    chk("rst_gnt", {30'd0, r0_gnt_a[0], r1_gnt_a[0]}, 32'd0);
    chk("rst_rvalid", {28'd0, r0_rvalid_a | r1_rvalid_a}, 32'd0);
    chk("rst_mem_en", {28'd0, mem_en_a | mem_we_a}, 32'd0);
    chk("rst_mem_addr", mem_addr_a[0], 32'd0);
    chk("rst_mem_wdata", mem_wdata_a[0], 32'd0);
    chk("rst_mem_wmask", {28'd0, mem_wmask_a[0]}, 32'd0);
    chk("rst_r0_rdata", r0_rdata_a[0], 32'd0);
    chk("rst_r1_rdata", r1_rdata_a[0], 32'd0);

    // Single read, latency 1
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10; r0_wmask = 4'hF;
    #1;
    chk("rd_r0_gnt_T", {31'd0, r0_gnt_a[0]}, 32'd1);
    chk("rd_r1_gnt_T", {31'd0, r1_gnt_a[0]}, 32'd0);
    cyc(); r0_req = 1'b0; #1;
    chk("rd_mem_en_T1", {31'd0, mem_en_a[0]}, 32'd1);
    chk("rd_mem_we_T1", {31'd0, mem_we_a[0]}, 32'd0);
    chk("rd_mem_wmask_T1", {28'd0, mem_wmask_a[0]}, 32'd0);
    chk("rd_mem_addr_T1", mem_addr_a[0], 32'h10);
    cyc(); #1;
    chk("rd_mem_en_T2", {31'd0, mem_en_a[0]}, 32'd0);
    chk("rd_rvalid_T2", {31'd0, r0_rvalid_a[0]}, 32'd0);
    cyc(); #1;
    chk("rd_rvalid_T3", {31'd0, r0_rvalid_a[0]}, 32'd1);
    chk("rd_rdata_T3", r0_rdata_a[0], 32'hDEAD_BEEF);
    chk("rd_r1_rvalid_T3", {31'd0, r1_rvalid_a[0]}, 32'd0);
    cyc(); #1;
    chk("rd_rvalid_T4", {31'd0, r0_rvalid_a[0]}, 32'd0);
    chk("rd_rdata_hold", r0_rdata_a[0], 32'hDEAD_BEEF);

    // Back-to-back writes from r1
    do_reset();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h100; r1_wdata = 32'h1234_5678; r1_wmask = 4'b0011;
    #1;
    chk("wr_gnt_T", {31'd0, r1_gnt_a[0]}, 32'd1);
    cyc();
    r1_addr = 32'h104; r1_wdata = 32'hCAFE_F00D; r1_wmask = 4'b1100;
    #1;
    chk("wr_gnt_T1", {31'd0, r1_gnt_a[0]}, 32'd0);
    chk("wr_mem_en_T1", {31'd0, mem_en_a[0]}, 32'd1);
    chk("wr_mem_we_T1", {31'd0, mem_we_a[0]}, 32'd1);
    chk("wr_mem_addr_T1", mem_addr_a[0], 32'h100);
    chk("wr_mem_wdata_T1", mem_wdata_a[0], 32'h1234_5678);
    chk("wr_mem_wmask_T1", {28'd0, mem_wmask_a[0]}, 32'h3);
    cyc(); #1;
    chk("wr_gnt2_T2", {31'd0, r1_gnt_a[0]}, 32'd1);
    chk("wr_mem_en_T2", {31'd0, mem_en_a[0]}, 32'd0);
    chk("wr_mem_we_T2", {31'd0, mem_we_a[0]}, 32'd0);
    chk("wr_mem_wmask_T2", {28'd0, mem_wmask_a[0]}, 32'd0);
    cyc(); r1_req = 1'b0; #1;
    chk("wr2_mem_en", {31'd0, mem_en_a[0]}, 32'd1);
    chk("wr2_mem_addr", mem_addr_a[0], 32'h104);
    chk("wr2_mem_wdata", mem_wdata_a[0], 32'hCAFE_F00D);
    chk("wr2_mem_wmask", {28'd0, mem_wmask_a[0]}, 32'hC);
    cyc(); #1;
    chk("wr_done_mem_en", {31'd0, mem_en_a[0]}, 32'd0);
    chk("wr_addr_hold", mem_addr_a[0], 32'h104);
    chk("wr_no_rvalid", {30'd0, r0_rvalid_a[0], r1_rvalid_a[0]}, 32'd0);

    // Contention: both read continuously, grants alternate r0 first
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h20;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h30;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_gnt;
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("cont_gnt_%0d", i), {30'd0, r1_gnt_a[0], r0_gnt_a[0]}, {30'd0, exp_gnt});
      cyc(); cyc(); cyc(); #1;
      chk($sformatf("cont_rvalid_%0d", i), {30'd0, r1_rvalid_a[0], r0_rvalid_a[0]}, {30'd0, exp_gnt});
      if (i % 2 == 0) chk($sformatf("cont_r0_rdata_%0d", i), r0_rdata_a[0], ~32'h20);
      else            chk($sformatf("cont_r1_rdata_%0d", i), r1_rdata_a[0], ~32'h30);
    end
    r0_req = 1'b0; r1_req = 1'b0;

    // Latency sweep 1..4: rvalid exactly MEM_LATENCY+2 cycles after gnt
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h40;
    #1;
    chk("sweep_gnt", {28'd0, r0_gnt_a}, 32'hF);
    for (int c = 1; c <= 7; c++) begin
      cyc(); r0_req = 1'b0; #1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sweep_rvalid_L%0d_c%0d", k + 1, c), {31'd0, r0_rvalid_a[k]}, {31'd0, c == k + 3});
        if (c == k + 3) chk($sformatf("sweep_rdata_L%0d", k + 1), r0_rdata_a[k], ~32'h40);
      end
    end

    // Reset during WAIT abandons the read and restores last_grant
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h50;
    #1;
    chk("rstw_gnt", {31'd0, r0_gnt_a[0]}, 32'd1);
    cyc(); r0_req = 1'b0; #1;
    chk("rstw_issue", {31'd0, mem_en_a[0]}, 32'd1);
    cyc(); rst_n = 1'b0; #1;
    chk("rstw_mem_addr", mem_addr_a[0], 32'd0);
    chk("rstw_mem_addr_L4", mem_addr_a[3], 32'd0);
    chk("rstw_mem_en", {28'd0, mem_en_a}, 32'd0);
    cyc(); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rstw_no_rvalid_%0d", c), {28'd0, r0_rvalid_a}, 32'd0);
      cyc();
    end
    r0_req = 1'b1; r0_addr = 32'h20; r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h30;
    #1;
    chk("rstw_tie_gnt", {30'd0, r1_gnt_a[0], r0_gnt_a[0]}, 32'b01);
    cyc(); r0_req = 1'b0; r1_req = 1'b0;

    // r1 request pulse during r0 WAIT is never granted
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h60;
    #1;
    chk("wd_gnt", {31'd0, r0_gnt_a[0]}, 32'd1);
    cyc(); r0_req = 1'b0;
    cyc();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h999; r1_wdata = 32'h1; r1_wmask = 4'hF;
    #1;
    chk("wd_r1_gnt_wait", {31'd0, r1_gnt_a[0]}, 32'd0);
    cyc(); r1_req = 1'b0; #1;
    chk("wd_r1_gnt_after", {31'd0, r1_gnt_a[0]}, 32'd0);
    chk("wd_r0_rvalid", {31'd0, r0_rvalid_a[0]}, 32'd1);
    chk("wd_r0_rdata", r0_rdata_a[0], ~32'h60);
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      chk($sformatf("wd_no_access_%0d", c), {31'd0, mem_en_a[0]}, 32'd0);
      chk($sformatf("wd_addr_hold_%0d", c), mem_addr_a[0], 32'h60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the single-port unified instruction/data memory of the multi-cycle RISC-V core. Port 0 serves the core's memory interface (instruction fetch and load/store); port 1 serves the program loader/debug path. The arbiter grants one requester at a time round-robin, drives the memory for exactly one issue cycle, waits out the memory read latency, and returns read data to the granted requester with a one-cycle valid pulse.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; byte mask width is DATA_W/8
- MEM_LATENCY, 1, cycles from memory issue cycle to mem_rdata valid; legal range 1-4
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- r0_req, r1_req  in  1  access request; must hold with stable fields until gnt
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  ADDR_W  byte address, passed through unmodified
- r0_wdata, r1_wdata  in  DATA_W  write data
- r0_wmask, r1_wmask  in  DATA_W/8  byte write enables
- r0_gnt, r1_gnt  out  1  request accepted this cycle (combinational)
- r0_rvalid, r1_rvalid  out  1  one-cycle read-return pulse (registered)
- r0_rdata, r1_rdata  out  DATA_W  read data, valid while rvalid=1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte mask
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after issue

## Operation
- States: IDLE, ISSUE, WAIT. Reset state IDLE.
- IDLE: if any req, select winner, assert winner's gnt combinationally, capture we/addr/wdata/wmask and winner id into registers, go to ISSUE. No req: stay.
- Selection: only one req -> that one. Both -> requester not equal to last_grant. last_grant updates on every gnt; reset value 1 (r0 wins first tie).
- ISSUE (exactly one cycle): mem_en=1; mem_we, mem_addr, mem_wdata, mem_wmask from captured registers. mem_wmask driven 0 for reads. Write -> IDLE. Read -> WAIT with latency counter loaded to 1.
- WAIT: counter increments each cycle; in the cycle counter == MEM_LATENCY, capture mem_rdata into winner's rdata register, set winner's rvalid for the next cycle, go to IDLE.
- rvalid is a registered single-cycle pulse; rdata holds its last value afterwards. Only the winning port's rdata updates.
- Outside ISSUE: mem_en=0, mem_we=0, mem_wmask=0; mem_addr/mem_wdata hold last captured values.
- Dropping req before gnt is legal and has no effect. gnt never asserts outside IDLE; req during ISSUE/WAIT waits.
- Reset mid-operation: state to IDLE, in-flight access abandoned, no rvalid issued for it.
- Reset values: all gnt/rvalid 0, mem_en/mem_we 0, mem_wmask 0, mem_addr/mem_wdata 0, r0_rdata/r1_rdata 0, counter 0, last_grant 1.

## Timing
- Read, grant in cycle T: ISSUE T+1; mem_rdata sampled in T+1+MEM_LATENCY; rvalid in T+2+MEM_LATENCY, same cycle IDLE may grant again.
- MEM_LATENCY=1 read: gnt T, mem_en T+1, rvalid T+3; back-to-back reads every 3 cycles.
- Write, grant in T: mem_en/mem_we T+1; next gnt possible at T+2.
- gnt is combinational from req in IDLE; all other outputs registered or decoded from state.

## Test plan
- Single read, MEM_LATENCY=1: r0 reads 0x0000_0010, memory returns 0xDEAD_BEEF -> r0_gnt at T, mem_en=1/mem_we=0/mem_wmask=0 at T+1, r0_rvalid=1 and r0_rdata=0xDEAD_BEEF at T+3 only; r1_rvalid stays 0.
- Write: r1 writes 0x1234_5678 to 0x0000_0100 mask 4'b0011 -> mem_en=1, mem_we=1, mem_addr=0x100, mem_wmask=4'b0011 for exactly one cycle; no rvalid; second r1 write granted 2 cycles after first.
- Contention: r0 and r1 both hold read requests continuously -> grants alternate r0, r1, r0, r1; each rvalid goes to the port granted; no port starved.
- Latency sweep MEM_LATENCY=1..4: read to fixed address -> rvalid exactly MEM_LATENCY+2 cycles after gnt; data captured from the correct cycle (mem_rdata driven valid only in that cycle).
- Reset in WAIT: assert rst_n=0 one cycle after ISSUE of an r0 read -> outputs go to reset values immediately; no r0_rvalid after release; first tie after reset grants r0.
- Request withdrawal: r1_req pulses for one cycle while r0 read in WAIT -> r1 never granted, no memory access for r1.
